// File: rtl/csr_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode CSR file / trap controller:
// CSR addresses, interrupt cause codes, mstatus/mcountinhibit bit positions,
// the FSM state type and the exception priority encoder.
package csr_trap_ctrl_pkg;
  localparam logic [11:0] A_MSTATUS   = 12'h300, A_MISA      = 12'h301,
                          A_MIE       = 12'h304, A_MTVEC     = 12'h305,
                          A_MCOUNTINH = 12'h320, A_MSCRATCH  = 12'h340,
                          A_MEPC      = 12'h341, A_MCAUSE    = 12'h342,
                          A_MTVAL     = 12'h343, A_MIP       = 12'h344,
                          A_MCYCLE    = 12'hB00, A_MINSTRET  = 12'hB02,
                          A_MCYCLEH   = 12'hB80, A_MINSTRETH = 12'hB82,
                          A_MVENDORID = 12'hF11, A_MARCHID   = 12'hF12,
                          A_MIMPID    = 12'hF13, A_MHARTID   = 12'hF14;

  localparam int MS_MIE = 3, MS_MPIE = 7, MS_MPP = 11;  // MPP occupies [12:11]
  localparam int CI_CY = 0, CI_IR = 2;

  localparam logic [4:0] IRQ_MSI = 5'd3, IRQ_MTI = 5'd7, IRQ_MEI = 5'd11;

  // Implemented synchronous exception causes: 0,2,3,4,6,11
  localparam logic [15:0] EXC_MASK = 16'h085D;

  // Exception priority, highest first
  localparam int NEXC = 6;
  localparam logic [3:0] EXC_PRIO [NEXC] = '{4'd3, 4'd0, 4'd2, 4'd11, 4'd4, 4'd6};

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;  // MXL=1, I

  typedef enum logic {ST_RUN, ST_TRAP} state_e;

  // Scan lowest priority first so the highest-priority hit is written last.
  function automatic logic [4:0] exc_pick(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = NEXC - 1; i >= 0; i--)
      if (v[EXC_PRIO[i]]) c = {1'b0, EXC_PRIO[i]};
    return c;
  endfunction

  function automatic logic exc_has_tval(input logic [4:0] c);
    return (c == 5'd0) || (c == 5'd2) || (c == 5'd4) || (c == 5'd6);
  endfunction
endpackage

// File: rtl/csr_trap_ctrl_counter.sv
// 64-bit free-running counter (mcycle / minstret).
// Ports: i_clk, i_rst (sync high), i_inc (count enable), i_wr_lo/i_wr_hi
// (replace one 32-bit half with i_wdata, overriding the increment), o_count.
module csr_trap_ctrl_counter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_count
);
  logic [63:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_cnt <= '0;
    else if (i_wr_lo) r_cnt[31:0]  <= i_wdata;
    else if (i_wr_hi) r_cnt[63:32] <= i_wdata;
    else if (i_inc)   r_cnt <= r_cnt + 64'd1;  // wraps naturally at 2^64
  end

  assign o_count = r_cnt;
endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap controller.
// Ports: CSR access (i_csr_*, o_csr_rdata/o_csr_illegal, combinational),
// MRET/retire/exception inputs, interrupt lines (registered once into mip),
// registered redirect pulses o_trap_valid/o_trap_target and o_xret_valid/o_epc.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          NIRQ        = 4,
  parameter logic [31:0] HART_ID     = '0,
  parameter logic [31:0] VENDOR_ID   = '0,
  parameter logic [31:0] RESET_MTVEC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csr_valid,
  input  logic [2:0]      i_csr_op,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  input  logic [4:0]      i_csr_uimm,
  input  logic            i_csr_src_nz,
  input  logic            i_csr_rd_nz,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_illegal,
  input  logic            i_mret_valid,
  input  logic            i_retire,
  input  logic [15:0]     i_exc_vec,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic [XLEN-1:0] i_cur_pc,
  input  logic            i_pipe_ready,
  input  logic            i_irq_msip,
  input  logic            i_irq_mtip,
  input  logic            i_irq_meip,
  input  logic [NIRQ-1:0] i_irq_local,
  output logic            o_trap_valid,
  output logic [XLEN-1:0] o_trap_target,
  output logic            o_xret_valid,
  output logic [XLEN-1:0] o_epc
);
  localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'd1 << NIRQ) - 32'd1) << 16);
  localparam logic [31:0] MTVEC_RST = {RESET_MTVEC[31:2], 1'b0, RESET_MTVEC[0]};

  logic r_ms_mie, r_ms_mpie;
  logic [1:0] r_ms_mpp;
  logic [31:0] r_mie, r_mtvec, r_mcountinh, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [NIRQ+2:0] r_irq;  // {local, meip, mtip, msip}
  logic [63:0] w_mcycle, w_minstret;
  state_e r_state;
  logic r_trap_valid, r_xret_valid;
  logic [31:0] r_trap_target;

  logic [31:0] w_mip, w_pend, w_old, w_new, w_src, w_mstatus, w_target;
  logic [4:0] w_irq_code, w_exc_code, w_code;
  logic w_known, w_wr_try, w_rd_en, w_irq_any;
  logic w_run, w_exc, w_irq, w_mret, w_csr_we;

  // ---------------- interrupts ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_irq <= '0;
    else       r_irq <= {i_irq_local, i_irq_meip, i_irq_mtip, i_irq_msip};
  end

  always_comb begin
    w_mip = '0;
    w_mip[IRQ_MSI] = r_irq[0];
    w_mip[IRQ_MTI] = r_irq[1];
    w_mip[IRQ_MEI] = r_irq[2];
    w_mip[16 +: NIRQ] = r_irq[3 +: NIRQ];
    w_pend = w_mip & r_mie & {32{r_ms_mie}};
    w_irq_any = |w_pend;
    // Platform lines: lowest index wins, then MTI < MSI < MEI overriding in turn.
    w_irq_code = '0;
    for (int i = 16 + NIRQ - 1; i >= 16; i--)
      if (w_pend[i]) w_irq_code = 5'(i);
    if (w_pend[IRQ_MTI]) w_irq_code = IRQ_MTI;
    if (w_pend[IRQ_MSI]) w_irq_code = IRQ_MSI;
    if (w_pend[IRQ_MEI]) w_irq_code = IRQ_MEI;
  end

  // ---------------- CSR read / op ----------------
  assign w_mstatus = {19'b0, r_ms_mpp, 3'b0, r_ms_mpie, 3'b0, r_ms_mie, 3'b0};

  always_comb begin
    w_known = 1'b1;
    case (i_csr_addr)
      A_MSTATUS:   w_old = w_mstatus;
      A_MISA:      w_old = MISA_VAL;
      A_MIE:       w_old = r_mie;
      A_MTVEC:     w_old = r_mtvec;
      A_MCOUNTINH: w_old = r_mcountinh;
      A_MSCRATCH:  w_old = r_mscratch;
      A_MEPC:      w_old = r_mepc;
      A_MCAUSE:    w_old = r_mcause;
      A_MTVAL:     w_old = r_mtval;
      A_MIP:       w_old = w_mip;
      A_MCYCLE:    w_old = w_mcycle[31:0];
      A_MCYCLEH:   w_old = w_mcycle[63:32];
      A_MINSTRET:  w_old = w_minstret[31:0];
      A_MINSTRETH: w_old = w_minstret[63:32];
      A_MVENDORID: w_old = VENDOR_ID;
      A_MARCHID:   w_old = '0;
      A_MIMPID:    w_old = '0;
      A_MHARTID:   w_old = HART_ID;
      default: begin w_old = '0; w_known = 1'b0; end
    endcase
  end

  assign w_src = i_csr_op[2] ? {27'b0, i_csr_uimm} : i_csr_wdata;

  always_comb begin
    case (i_csr_op[1:0])
      2'b01:   w_new = w_src;
      2'b10:   w_new = w_old | w_src;
      2'b11:   w_new = w_old & ~w_src;
      default: w_new = w_old;
    endcase
  end

  // RW always writes; set/clear only write with a non-zero source.
  assign w_wr_try = i_csr_valid && ((i_csr_op[1:0] == 2'b01) ||
                                    ((i_csr_op[1:0] != 2'b00) && i_csr_src_nz));
  assign w_rd_en  = !((i_csr_op[1:0] == 2'b01) && !i_csr_rd_nz);
  assign o_csr_illegal = i_csr_valid && (!w_known || (w_wr_try && (i_csr_addr[11:10] == 2'b11)));
  assign o_csr_rdata   = (i_csr_valid && !o_csr_illegal && w_rd_en) ? w_old : '0;

  // ---------------- arbitration ----------------
  assign w_run    = (r_state == ST_RUN);
  assign w_exc    = w_run && |(i_exc_vec & EXC_MASK);
  assign w_irq    = w_run && !w_exc && i_pipe_ready && w_irq_any;
  assign w_mret   = w_run && !w_exc && !w_irq && i_mret_valid;
  assign w_csr_we = w_run && !w_exc && !w_irq && !i_mret_valid && w_wr_try && !o_csr_illegal;

  assign w_exc_code = exc_pick(i_exc_vec);
  assign w_code     = w_exc ? w_exc_code : w_irq_code;
  assign w_target   = (w_irq && r_mtvec[0]) ? ({r_mtvec[31:2], 2'b00} + {25'b0, w_code, 2'b00})
                                            : {r_mtvec[31:2], 2'b00};

  // ---------------- CSR state ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ms_mie <= 1'b0; r_ms_mpie <= 1'b0; r_ms_mpp <= 2'b00;
      r_mie <= '0; r_mtvec <= MTVEC_RST; r_mcountinh <= '0; r_mscratch <= '0;
      r_mepc <= '0; r_mcause <= '0; r_mtval <= '0;
    end else if (w_exc || w_irq) begin
      r_mepc    <= {i_cur_pc[31:2], 2'b00};
      r_mcause  <= {w_irq, 26'b0, w_code};
      r_mtval   <= (w_exc && exc_has_tval(w_code)) ? i_exc_tval : '0;
      r_ms_mpie <= r_ms_mie;
      r_ms_mie  <= 1'b0;
      r_ms_mpp  <= 2'b11;
    end else if (w_mret) begin
      r_ms_mie  <= r_ms_mpie;
      r_ms_mpie <= 1'b1;
      r_ms_mpp  <= 2'b11;
    end else if (w_csr_we) begin
      case (i_csr_addr)
        A_MSTATUS: begin
          r_ms_mie  <= w_new[MS_MIE];
          r_ms_mpie <= w_new[MS_MPIE];
          r_ms_mpp  <= {2{&w_new[MS_MPP +: 2]}};  // only M-mode is legal
        end
        A_MIE:       r_mie       <= w_new & MIE_MASK;
        A_MTVEC:     r_mtvec     <= {w_new[31:2], 1'b0, w_new[0]};
        A_MCOUNTINH: r_mcountinh <= w_new & 32'h0000_0005;
        A_MSCRATCH:  r_mscratch  <= w_new;
        A_MEPC:      r_mepc      <= {w_new[31:2], 2'b00};
        A_MCAUSE:    r_mcause    <= w_new;
        A_MTVAL:     r_mtval     <= w_new;
        default: ;  // mip and counters are handled elsewhere or read-only
      endcase
    end
  end

  // ---------------- counters ----------------
  csr_trap_ctrl_counter u_mcycle (
    .i_clk(i_clk), .i_rst(i_rst), .i_inc(!r_mcountinh[CI_CY]),
    .i_wr_lo(w_csr_we && (i_csr_addr == A_MCYCLE)),
    .i_wr_hi(w_csr_we && (i_csr_addr == A_MCYCLEH)),
    .i_wdata(w_new), .o_count(w_mcycle)
  );

  csr_trap_ctrl_counter u_minstret (
    .i_clk(i_clk), .i_rst(i_rst), .i_inc(i_retire && !r_mcountinh[CI_IR]),
    .i_wr_lo(w_csr_we && (i_csr_addr == A_MINSTRET)),
    .i_wr_hi(w_csr_we && (i_csr_addr == A_MINSTRETH)),
    .i_wdata(w_new), .o_count(w_minstret)
  );

  // ---------------- redirect FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN; r_trap_valid <= 1'b0; r_xret_valid <= 1'b0; r_trap_target <= '0;
    end else begin
      r_trap_valid <= 1'b0;
      r_xret_valid <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_exc || w_irq) begin
            r_state <= ST_TRAP; r_trap_valid <= 1'b1; r_trap_target <= w_target;
          end else if (w_mret) begin
            r_state <= ST_TRAP; r_xret_valid <= 1'b1;
          end
        end
        ST_TRAP: r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_trap_valid  = r_trap_valid;
  assign o_trap_target = r_trap_target;
  assign o_xret_valid  = r_xret_valid;
  assign o_epc         = r_mepc;
endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;
  localparam int NIRQ = 4;
  localparam logic [31:0] HART = 32'd3, VEND = 32'h55;

  logic clk = 1'b0, rst = 1'b1;
  logic csr_valid = 0, csr_src_nz = 0, csr_rd_nz = 0, csr_illegal;
  logic [2:0] csr_op = 0;
  logic [11:0] csr_addr = 0;
  logic [31:0] csr_wdata = 0, csr_rdata, exc_tval = 0, cur_pc = 0, trap_target, epc;
  logic [4:0] csr_uimm = 0;
  logic mret_valid = 0, retire = 0, pipe_ready = 0;
  logic [15:0] exc_vec = 0;
  logic irq_msip = 0, irq_mtip = 0, irq_meip = 0;
  logic [NIRQ-1:0] irq_local = 0;
  logic trap_valid, xret_valid;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.XLEN(32), .NIRQ(NIRQ), .HART_ID(HART), .VENDOR_ID(VEND), .RESET_MTVEC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst), .i_csr_valid(csr_valid), .i_csr_op(csr_op), .i_csr_addr(csr_addr),
    .i_csr_wdata(csr_wdata), .i_csr_uimm(csr_uimm), .i_csr_src_nz(csr_src_nz), .i_csr_rd_nz(csr_rd_nz),
    .o_csr_rdata(csr_rdata), .o_csr_illegal(csr_illegal), .i_mret_valid(mret_valid), .i_retire(retire),
    .i_exc_vec(exc_vec), .i_exc_tval(exc_tval), .i_cur_pc(cur_pc), .i_pipe_ready(pipe_ready),
    .i_irq_msip(irq_msip), .i_irq_mtip(irq_mtip), .i_irq_meip(irq_meip), .i_irq_local(irq_local),
    .o_trap_valid(trap_valid), .o_trap_target(trap_target), .o_xret_valid(xret_valid), .o_epc(epc)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Side-effect-free read (CSRRS with rs1=x0), sampled 1 ns after driving.
  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d, output logic ill);
    csr_valid = 1; csr_op = 3'd2; csr_addr = a; csr_wdata = 0; csr_src_nz = 0; csr_rd_nz = 1;
    #1; d = csr_rdata; ill = csr_illegal; csr_valid = 0;
  endtask

  task automatic csr_wr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] v);
    csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = v; csr_uimm = v[4:0];
    csr_src_nz = (v != 0); csr_rd_nz = 1;
    tick(); csr_valid = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic ill;
    rst = 1; tick(); tick();
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL rst_trap_valid: got %h expected 0", trap_valid); end
    n_cmp++; if (xret_valid !== 1'b0) begin n_bad++; $display("FAIL rst_xret_valid: got %h expected 0", xret_valid); end
    rst = 0;
    csr_rd(12'h301, d, ill);
    n_cmp++; if (d !== 32'h4000_0100) begin n_bad++; $display("FAIL rst_misa: got %h expected 40000100", d); end
    csr_rd(12'h305, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mtvec: got %h expected 0", d); end
    csr_rd(12'h300, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mstatus: got %h expected 0", d); end
    csr_rd(12'hB00, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mcycle: got %h expected 0", d); end
    csr_rd(12'hF11, d, ill);
    n_cmp++; if (d !== VEND) begin n_bad++; $display("FAIL rst_mvendorid: got %h expected %h", d, VEND); end
  endtask

  task automatic test_exc_trap();
    logic [31:0] d; logic ill;
    tick();
    csr_wr(3'd1, 12'h305, 32'h100);
    csr_wr(3'd1, 12'h300, 32'h8);
    exc_vec = 16'h0004; cur_pc = 32'h40; exc_tval = 32'hDEAD_BEEF;
    tick(); exc_vec = 0;
    n_cmp++; if (trap_valid !== 1'b1) begin n_bad++; $display("FAIL exc_trap_valid: got %h expected 1", trap_valid); end
    n_cmp++; if (trap_target !== 32'h100) begin n_bad++; $display("FAIL exc_target: got %h expected 100", trap_target); end
    n_cmp++; if (epc !== 32'h40) begin n_bad++; $display("FAIL exc_mepc: got %h expected 40", epc); end
    csr_rd(12'h342, d, ill);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL exc_mcause: got %h expected 2", d); end
    csr_rd(12'h343, d, ill);
    n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL exc_mtval: got %h expected deadbeef", d); end
    csr_rd(12'h300, d, ill);
    n_cmp++; if (d !== 32'h1880) begin n_bad++; $display("FAIL exc_mstatus: got %h expected 1880", d); end
    tick();
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL exc_pulse_end: got %h expected 0", trap_valid); end
  endtask

  task automatic test_mret();
    logic [31:0] d; logic ill;
    mret_valid = 1; tick(); mret_valid = 0;
    n_cmp++; if (xret_valid !== 1'b1) begin n_bad++; $display("FAIL mret_xret_valid: got %h expected 1", xret_valid); end
    n_cmp++; if (epc !== 32'h40) begin n_bad++; $display("FAIL mret_epc: got %h expected 40", epc); end
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL mret_no_trap: got %h expected 0", trap_valid); end
    csr_rd(12'h300, d, ill);
    n_cmp++; if (d !== 32'h1888) begin n_bad++; $display("FAIL mret_mstatus: got %h expected 1888", d); end
    tick();
    n_cmp++; if (xret_valid !== 1'b0) begin n_bad++; $display("FAIL mret_pulse_end: got %h expected 0", xret_valid); end
  endtask

  task automatic test_irq_vectored();
    logic [31:0] d; logic ill;
    csr_wr(3'd1, 12'h305, 32'h203);
    csr_rd(12'h305, d, ill);
    n_cmp++; if (d !== 32'h201) begin n_bad++; $display("FAIL mtvec_warl: got %h expected 201", d); end
    csr_wr(3'd1, 12'h304, 32'hFFFF_FFFF);
    csr_rd(12'h304, d, ill);
    n_cmp++; if (d !== 32'h000F_0888) begin n_bad++; $display("FAIL mie_warl: got %h expected 000f0888", d); end
    csr_wr(3'd1, 12'h304, 32'h80);
    irq_mtip = 1; pipe_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL irq_blocked_%0d: got %h expected 0", i, trap_valid); end
    end
    csr_rd(12'h344, d, ill);
    n_cmp++; if (d !== 32'h80) begin n_bad++; $display("FAIL irq_mip: got %h expected 80", d); end
    pipe_ready = 1; tick(); pipe_ready = 0; irq_mtip = 0;
    n_cmp++; if (trap_valid !== 1'b1) begin n_bad++; $display("FAIL irq_trap_valid: got %h expected 1", trap_valid); end
    n_cmp++; if (trap_target !== 32'h21C) begin n_bad++; $display("FAIL irq_target: got %h expected 21c", trap_target); end
    csr_rd(12'h342, d, ill);
    n_cmp++; if (d !== 32'h8000_0007) begin n_bad++; $display("FAIL irq_mcause: got %h expected 80000007", d); end
    csr_rd(12'h343, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL irq_mtval: got %h expected 0", d); end
    tick();
    mret_valid = 1; tick(); mret_valid = 0; tick();
  endtask

  task automatic test_priority();
    logic [31:0] d; logic ill;
    csr_wr(3'd1, 12'h304, 32'h800);
    irq_meip = 1; tick(); tick();
    exc_vec = 16'h0808; cur_pc = 32'h83; exc_tval = 32'h1111; pipe_ready = 1;
    tick(); exc_vec = 0;
    n_cmp++; if (trap_valid !== 1'b1) begin n_bad++; $display("FAIL prio_trap_valid: got %h expected 1", trap_valid); end
    n_cmp++; if (trap_target !== 32'h200) begin n_bad++; $display("FAIL prio_target: got %h expected 200", trap_target); end
    n_cmp++; if (epc !== 32'h80) begin n_bad++; $display("FAIL prio_mepc_align: got %h expected 80", epc); end
    csr_rd(12'h342, d, ill);
    n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL prio_mcause: got %h expected 3", d); end
    csr_rd(12'h343, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL prio_mtval: got %h expected 0", d); end
    csr_rd(12'h344, d, ill);
    n_cmp++; if (d !== 32'h800) begin n_bad++; $display("FAIL prio_mip: got %h expected 800", d); end
    tick();
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL prio_masked_1: got %h expected 0", trap_valid); end
    tick();
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL prio_masked_2: got %h expected 0", trap_valid); end
    mret_valid = 1; tick(); mret_valid = 0;
    n_cmp++; if (xret_valid !== 1'b1) begin n_bad++; $display("FAIL prio_xret: got %h expected 1", xret_valid); end
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL prio_no_trap_in_xret: got %h expected 0", trap_valid); end
    tick();
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL prio_trap_state_blocks: got %h expected 0", trap_valid); end
    tick();
    n_cmp++; if (trap_valid !== 1'b1) begin n_bad++; $display("FAIL prio_irq_taken: got %h expected 1", trap_valid); end
    n_cmp++; if (trap_target !== 32'h22C) begin n_bad++; $display("FAIL prio_irq_target: got %h expected 22c", trap_target); end
    csr_rd(12'h342, d, ill);
    n_cmp++; if (d !== 32'h8000_000B) begin n_bad++; $display("FAIL prio_irq_mcause: got %h expected 8000000b", d); end
    irq_meip = 0; pipe_ready = 0;
    tick();
    mret_valid = 1; tick(); mret_valid = 0; tick();
  endtask

  task automatic test_counters();
    logic [31:0] d; logic ill;
    csr_wr(3'd1, 12'hB00, 32'hFFFF_FFFF);
    csr_rd(12'hB00, d, ill);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cyc_lo_written: got %h expected ffffffff", d); end
    csr_rd(12'hB80, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL cyc_hi_before: got %h expected 0", d); end
    tick();
    csr_rd(12'hB00, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL cyc_lo_carry: got %h expected 0", d); end
    csr_rd(12'hB80, d, ill);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL cyc_hi_carry: got %h expected 1", d); end
    csr_wr(3'd1, 12'hB00, 32'h1234);
    csr_rd(12'hB00, d, ill);
    n_cmp++; if (d !== 32'h1234) begin n_bad++; $display("FAIL cyc_write_wins: got %h expected 1234", d); end
    csr_rd(12'hB80, d, ill);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL cyc_hi_kept: got %h expected 1", d); end
    tick();
    csr_rd(12'hB00, d, ill);
    n_cmp++; if (d !== 32'h1235) begin n_bad++; $display("FAIL cyc_resume: got %h expected 1235", d); end
    csr_wr(3'd1, 12'h320, 32'h5);
    csr_wr(3'd1, 12'hB00, 32'h50);
    tick(); tick(); tick();
    csr_rd(12'hB00, d, ill);
    n_cmp++; if (d !== 32'h50) begin n_bad++; $display("FAIL cyc_inhibit: got %h expected 50", d); end
    csr_wr(3'd1, 12'hB80, 32'hFFFF_FFFF);
    csr_wr(3'd1, 12'hB00, 32'hFFFF_FFFE);
    csr_wr(3'd1, 12'h320, 32'h0);
    tick(); tick();
    csr_rd(12'hB00, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL cyc_wrap_lo: got %h expected 0", d); end
    csr_rd(12'hB80, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL cyc_wrap_hi: got %h expected 0", d); end
    csr_wr(3'd1, 12'hB02, 32'h10);
    retire = 1; tick(); tick(); tick(); retire = 0; tick();
    csr_rd(12'hB02, d, ill);
    n_cmp++; if (d !== 32'h13) begin n_bad++; $display("FAIL instret_count: got %h expected 13", d); end
    csr_wr(3'd1, 12'h320, 32'h4);
    retire = 1; tick(); tick(); retire = 0;
    csr_rd(12'hB02, d, ill);
    n_cmp++; if (d !== 32'h13) begin n_bad++; $display("FAIL instret_inhibit: got %h expected 13", d); end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic ill;
    csr_wr(3'd1, 12'h340, 32'hA5);
    csr_valid = 1; csr_op = 3'd1; csr_addr = 12'hF14; csr_wdata = 32'h9; csr_src_nz = 1; csr_rd_nz = 1;
    #1;
    n_cmp++; if (csr_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_hartid_rw: got %h expected 1", csr_illegal); end
    n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL ill_hartid_rdata: got %h expected 0", csr_rdata); end
    tick(); csr_valid = 0;
    csr_rd(12'hF14, d, ill);
    n_cmp++; if (d !== HART) begin n_bad++; $display("FAIL hartid_read: got %h expected %h", d, HART); end
    n_cmp++; if (ill !== 1'b0) begin n_bad++; $display("FAIL hartid_read_legal: got %h expected 0", ill); end
    csr_valid = 1; csr_op = 3'd2; csr_addr = 12'hF14; csr_wdata = 32'h1; csr_src_nz = 1;
    #1;
    n_cmp++; if (csr_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_hartid_rs: got %h expected 1", csr_illegal); end
    tick(); csr_valid = 0;
    csr_valid = 1; csr_op = 3'd1; csr_addr = 12'h7C0; csr_wdata = 32'h77; csr_src_nz = 1;
    #1;
    n_cmp++; if (csr_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_unknown: got %h expected 1", csr_illegal); end
    tick(); csr_valid = 0;
    csr_rd(12'h340, d, ill);
    n_cmp++; if (d !== 32'hA5) begin n_bad++; $display("FAIL ill_no_change: got %h expected a5", d); end
    csr_valid = 1; csr_op = 3'd1; csr_addr = 12'h340; csr_wdata = 32'h5A; csr_src_nz = 1; csr_rd_nz = 0;
    #1;
    n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL rw_rd_x0: got %h expected 0", csr_rdata); end
    tick(); csr_valid = 0;
    csr_rd(12'h340, d, ill);
    n_cmp++; if (d !== 32'h5A) begin n_bad++; $display("FAIL rw_write: got %h expected 5a", d); end
    csr_wr(3'd7, 12'h340, 32'h0F);
    csr_rd(12'h340, d, ill);
    n_cmp++; if (d !== 32'h50) begin n_bad++; $display("FAIL rci_clear: got %h expected 50", d); end
  endtask

  task automatic test_reset_mid_trap();
    logic [31:0] d; logic ill;
    exc_vec = 16'h0001; cur_pc = 32'h300; rst = 1;
    tick(); exc_vec = 0;
    n_cmp++; if (trap_valid !== 1'b0) begin n_bad++; $display("FAIL rst_drops_trap: got %h expected 0", trap_valid); end
    rst = 0;
    csr_rd(12'h342, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst2_mcause: got %h expected 0", d); end
    csr_rd(12'hB00, d, ill);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst2_mcycle: got %h expected 0", d); end
    tick();
    csr_rd(12'hB00, d, ill);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL rst2_mcycle_runs: got %h expected 1", d); end
  endtask

  initial begin
    test_reset();
    test_exc_trap();
    test_mret();
    test_irq_vectored();
    test_priority();
    test_counters();
    test_illegal();
    test_reset_mid_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
